sram_rw_minion: RTL and testbench

//  Parametrised single-port SRAM with a latency-insensitive val/rdy request/response interface.

---
 rtl/sram_rw_pkg.sv | 14 +
 rtl/sram_SRAM_generic.sv | 43 ++++
 rtl/sram_rw_resp_queue.sv | 61 ++++++
 rtl/sram_rw_minion.sv | 153 +++++++++++++++
 tb/tb_sram_rw_minion.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_rw_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram_rw_pkg
// Brief  : Shared request-type and clear-FSM encodings for sram_rw_minion.
// Rev    : 1.0
// ============================================================================
package sram_rw_pkg;

    typedef enum logic {SRAM_RD = 1'b0, SRAM_WR = 1'b1} sram_req_type_e;

    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} sram_clr_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_SRAM_generic.sv
`default_nettype none
// ============================================================================
// Module : sram_SRAM_generic
// Brief  : Behavioural single-port SRAM macro; active-low csb/web, byte mask,
//          one-cycle registered read.
// Rev    : 1.0
// ============================================================================
module sram_SRAM_generic #(
    parameter int p_data_nbits  = 128,
    parameter int p_num_entries = 256
) (
    input  logic                             clk0,
    input  logic                             web0,
    input  logic                             csb0,
    input  logic [p_data_nbits/8-1:0]        wmask0,
    input  logic [$clog2(p_num_entries)-1:0] addr0,
    input  logic [p_data_nbits-1:0]          din0,
    output logic [p_data_nbits-1:0]          dout0
);

    localparam int c_MASK_W = p_data_nbits / 8;

    logic [p_data_nbits-1:0] r_mem [p_num_entries];
    logic [p_data_nbits-1:0] r_dout;

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < c_MASK_W; i++) begin
                    if (wmask0[i]) begin
                        r_mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
                    end
                end
            end else begin
                r_dout <= r_mem[addr0];
            end
        end
    end

    assign dout0 = r_dout;

endmodule
`default_nettype wire

// File: rtl/sram_rw_resp_queue.sv
`default_nettype none
// ============================================================================
// Module : sram_rw_resp_queue
// Brief  : Plain circular FIFO for responses; upstream credits prevent overflow.
// Rev    : 1.0
// ============================================================================
module sram_rw_resp_queue #(
    parameter int p_depth = 3,
    parameter int p_nbits = 129
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg
);

    localparam int c_PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int c_CNT_W = $clog2(p_depth + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(p_depth - 1);

    logic [p_nbits-1:0] r_buf [p_depth];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_deq_fire;

    assign deq_val    = (r_count != '0);
    assign deq_msg    = r_buf[r_rd_ptr];
    assign w_deq_fire = deq_val && deq_rdy;

    always_ff @(posedge clk) begin
        if (enq_val) begin
            r_buf[r_wr_ptr] <= enq_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (enq_val) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq_fire) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({enq_val, w_deq_fire})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_rw_minion.sv
`default_nettype none
// ============================================================================
// Module : sram_rw_minion
// Brief  : val/rdy SRAM minion with zero-clear, M1 stage and credit-limited
//          response queue.
// Rev    : 1.0
// ============================================================================
module sram_rw_minion
    import sram_rw_pkg::*;
#(
    parameter int p_data_nbits      = 128,
    parameter int p_num_entries     = 256,
    parameter int p_max_outstanding = 3,
    parameter int p_clear_on_reset  = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_val,
    output logic                             req_rdy,
    input  logic                             req_type,
    input  logic [$clog2(p_num_entries)-1:0] req_addr,
    input  logic [p_data_nbits/8-1:0]        req_wmask,
    input  logic [p_data_nbits-1:0]          req_data,
    output logic                             resp_val,
    input  logic                             resp_rdy,
    output logic                             resp_type,
    output logic [p_data_nbits-1:0]          resp_data,
    output logic                             clear_done
);

    localparam int c_ADDR_W = $clog2(p_num_entries);
    localparam int c_MASK_W = p_data_nbits / 8;
    localparam int c_CNT_W  = $clog2(p_max_outstanding + 1);

    localparam logic [0:0] c_ST_CLEAR = 1'(ST_CLEAR);
    localparam logic [0:0] c_ST_READY = 1'(ST_READY);
    localparam logic [0:0] c_ST_INIT  = (p_clear_on_reset != 0) ? c_ST_CLEAR : c_ST_READY;

    localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = c_ADDR_W'(p_num_entries - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX   = c_CNT_W'(p_max_outstanding);

    logic [0:0]              r_state;
    logic [c_ADDR_W-1:0]     r_clr_addr;
    logic [c_CNT_W-1:0]      r_count;
    logic                    r_m1_val;
    logic                    r_m1_type;

    logic                    w_req_fire;
    logic                    w_resp_fire;
    logic                    w_clearing;
    logic                    w_web;
    logic                    w_csb;
    logic [c_MASK_W-1:0]     w_wmask;
    logic [c_ADDR_W-1:0]     w_addr;
    logic [p_data_nbits-1:0] w_din;
    logic [p_data_nbits-1:0] w_dout;
    logic [p_data_nbits:0]   w_enq_msg;
    logic [p_data_nbits:0]   w_deq_msg;

    // req_rdy depends only on registered state, keeping resp_rdy off this path
    assign req_rdy     = (r_state == c_ST_READY) && (r_count < c_CNT_MAX);
    assign clear_done  = (r_state == c_ST_READY);
    assign w_clearing  = (r_state == c_ST_CLEAR);
    assign w_req_fire  = req_val && req_rdy;
    assign w_resp_fire = resp_val && resp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_INIT;
            r_clr_addr <= '0;
        end else if (w_clearing) begin
            r_clr_addr <= r_clr_addr + c_ADDR_W'(1);
            if (r_clr_addr == c_ADDR_LAST) begin
                r_state <= c_ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_req_fire, w_resp_fire})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m1_val  <= 1'b0;
            r_m1_type <= 1'b0;
        end else begin
            r_m1_val  <= w_req_fire;
            r_m1_type <= req_type;
        end
    end

    always_comb begin
        w_csb   = 1'b1;
        w_web   = 1'b1;
        w_wmask = '0;
        w_addr  = req_addr;
        w_din   = req_data;
        if (w_clearing) begin
            w_csb   = 1'b0;
            w_web   = 1'b0;
            w_wmask = '1;
            w_addr  = r_clr_addr;
            w_din   = '0;
        end else if (w_req_fire) begin
            w_csb   = 1'b0;
            w_web   = (req_type != SRAM_WR);
            w_wmask = (req_type == SRAM_WR) ? req_wmask : '0;
        end
    end

    sram_SRAM_generic #(
        .p_data_nbits  (p_data_nbits),
        .p_num_entries (p_num_entries)
    ) u_sram (
        .clk0   (clk),
        .web0   (w_web),
        .csb0   (w_csb),
        .wmask0 (w_wmask),
        .addr0  (w_addr),
        .din0   (w_din),
        .dout0  (w_dout)
    );

    // Write responses carry zero data; the macro output is only meaningful for reads
    assign w_enq_msg = {r_m1_type, (r_m1_type == SRAM_WR) ? '0 : w_dout};

    sram_rw_resp_queue #(
        .p_depth (p_max_outstanding),
        .p_nbits (p_data_nbits + 1)
    ) u_resp_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (r_m1_val),
        .enq_msg (w_enq_msg),
        .deq_val (resp_val),
        .deq_rdy (resp_rdy),
        .deq_msg (w_deq_msg)
    );

    assign resp_type = w_deq_msg[p_data_nbits];
    assign resp_data = w_deq_msg[p_data_nbits-1:0];

endmodule
`default_nettype wire

// File: tb/tb_sram_rw_minion.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_rw_minion
// Brief  : Self-checking bench: directed vectors plus random traffic against a
//          word-array/queue reference model.
// Rev    : 1.0
// ============================================================================
module tb_sram_rw_minion;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_val = 1'b0;
    logic         req_rdy;
    logic         req_type = 1'b0;
    logic [7:0]   req_addr = '0;
    logic [15:0]  req_wmask = '0;
    logic [127:0] req_data = '0;
    logic         resp_val;
    logic         resp_rdy = 1'b0;
    logic         resp_type;
    logic [127:0] resp_data;
    logic         clear_done;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    sram_rw_minion #(
        .p_data_nbits      (128),
        .p_num_entries     (256),
        .p_max_outstanding (3),
        .p_clear_on_reset  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_data   (req_data),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_type  (resp_type),
        .resp_data  (resp_data),
        .clear_done (clear_done)
    );

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: memory contents as an array, pending responses as a queue
    logic [127:0] mdl_mem [256];
    logic [128:0] exp_q [$];

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
        end else begin
            if (resp_val && resp_rdy) begin
                if (exp_q.size() == 0) chk("resp_unexpected", {resp_type, resp_data}, 'x);
                else chk("resp_model", {resp_type, resp_data}, exp_q.pop_front());
            end
            if (req_val && req_rdy) begin
                if (req_type) begin
                    for (int b = 0; b < 16; b++)
                        if (req_wmask[b]) mdl_mem[req_addr][b*8 +: 8] = req_data[b*8 +: 8];
                    exp_q.push_back({1'b1, 128'h0});
                end else begin
                    exp_q.push_back({1'b0, mdl_mem[req_addr]});
                end
            end
        end
    end

    typedef struct {
        logic         typ;
        logic [7:0]   addr;
        logic [15:0]  mask;
        logic [127:0] data;
        logic [128:0] exp;
    } vec_t;

    vec_t vecs [$];

    task automatic send(input logic t, input logic [7:0] a, input logic [15:0] m, input logic [127:0] d);
        int n = 0;
        @(posedge clk); #1;
        req_val = 1'b1; req_type = t; req_addr = a; req_wmask = m; req_data = d;
        @(negedge clk);
        while (!req_rdy && n < 50) begin @(negedge clk); n++; end
        if (!req_rdy) chk("send_timeout", 129'(req_rdy), 129'(1));
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    task automatic get_resp(output logic [128:0] r);
        int n = 0;
        @(negedge clk);
        while (!resp_val && n < 50) begin @(negedge clk); n++; end
        if (!resp_val) chk("resp_timeout", 129'(resp_val), 129'(1));
        r = {resp_type, resp_data};
    endtask

    task automatic drain();
        int n = 0;
        resp_rdy = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain_empty", 129'(exp_q.size()), 129'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_val = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 129'(req_rdy), 129'(0));
        chk("rst_resp_val", 129'(resp_val), 129'(0));
        chk("rst_clear_done", 129'(clear_done), 129'(0));
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_clear();
        int n = 0;
        logic rdy_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (clear_done || n >= 1000) break;
            if (req_rdy) rdy_seen = 1'b1;
            n++;
        end
        chk("clear_cycles", 129'(n), 129'(256));
        chk("clear_rdy_low", 129'(rdy_seen), 129'(0));
        chk("clear_done_ready", 129'(req_rdy), 129'(1));
    endtask

    task automatic credit_test(input logic [7:0] base);
        int acc = 0;
        resp_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            req_val = 1'b1; req_type = 1'b0; req_addr = base + 8'(acc);
            @(negedge clk);
            if (req_rdy) acc++;
        end
        @(posedge clk); #1;
        req_val = 1'b0; resp_rdy = 1'b1;
        chk("credit_accepted", 129'(acc), 129'(3));
        @(negedge clk);
        chk("credit_full_rdy", 129'({resp_val, req_rdy}), 129'(2'b10));
        @(negedge clk);
        chk("credit_return_rdy", 129'(req_rdy), 129'(1));
        drain();
    endtask

    logic [128:0] r;

    initial begin
        // Test 1: clear after reset, then last word reads zero
        do_reset();
        wait_clear();
        resp_rdy = 1'b1;

        // Test 2: write/read latency
        @(posedge clk); #1;
        req_val = 1'b1; req_type = 1'b1; req_addr = 8'd5; req_wmask = 16'hFFFF;
        req_data = {96'h0123456789ABCDEF01234567, 32'hDEADBEEF};
        @(negedge clk);
        chk("t2_wr_fire", 129'(req_rdy), 129'(1));
        @(posedge clk); #1;
        req_type = 1'b0;
        @(negedge clk);
        chk("t2_n1_resp_val", 129'(resp_val), 129'(0));
        @(posedge clk); #1;
        req_val = 1'b0;
        @(negedge clk);
        chk("t2_n2_wr_resp", {resp_val, resp_type, resp_data}, {2'b11, 128'h0});
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_n3_rd_resp", {resp_val, resp_type, resp_data},
            {2'b10, 96'h0123456789ABCDEF01234567, 32'hDEADBEEF});
        @(negedge clk);
        chk("t2_idle", 129'(resp_val), 129'(0));

        // Test 1 tail and Test 3 (byte mask) as a vector table
        vecs.push_back('{1'b0, 8'hFF, 16'h0000, 128'h0, {1'b0, 128'h0}});
        vecs.push_back('{1'b1, 8'h07, 16'hFFFF, {128{1'b1}}, {1'b1, 128'h0}});
        vecs.push_back('{1'b1, 8'h07, 16'h0001, 128'h0, {1'b1, 128'h0}});
        vecs.push_back('{1'b0, 8'h07, 16'h0000, 128'h0, {1'b0, {120{1'b1}}, 8'h00}});
        vecs.push_back('{1'b1, 8'h09, 16'hFFFF, {16{8'h11}}, {1'b1, 128'h0}});
        vecs.push_back('{1'b1, 8'h09, 16'h00FF, {16{8'h22}}, {1'b1, 128'h0}});
        vecs.push_back('{1'b0, 8'h09, 16'hFFFF, 128'h0, {1'b0, {8{8'h11}}, {8{8'h22}}}});
        vecs.push_back('{1'b0, 8'h05, 16'h0000, 128'h0, {1'b0, 96'h0123456789ABCDEF01234567, 32'hDEADBEEF}});
        foreach (vecs[i]) begin
            send(vecs[i].typ, vecs[i].addr, vecs[i].mask, vecs[i].data);
            get_resp(r);
            chk($sformatf("vec%0d", i), r, vecs[i].exp);
        end
        drain();

        // Test 4: 20 back-to-back reads
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            req_val = (i < 20); req_type = 1'b0; req_addr = 8'(i);
            @(negedge clk);
            if (i < 20) chk($sformatf("stream_rdy%0d", i), 129'(req_rdy), 129'(1));
            if (i >= 2) chk($sformatf("stream_resp%0d", i), 129'(resp_val), 129'(1));
        end
        drain();

        // Test 5: credit limit under backpressure
        credit_test(8'd20);

        // Random traffic, including same-address read-after-write
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            req_val   = 1'($urandom_range(0, 1));
            req_type  = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom_range(0, 7));
            req_wmask = 16'($urandom);
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            resp_rdy  = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        req_val = 1'b0;
        drain();

        // Test 6: reset with reads outstanding, then reset again mid-clear
        send(1'b1, 8'h00, 16'hFFFF, {4{32'hA5A5A5A5}});
        send(1'b1, 8'hFF, 16'hFFFF, {4{32'h5A5A5A5A}});
        drain();
        resp_rdy = 1'b0;
        send(1'b0, 8'h00, 16'h0, 128'h0);
        send(1'b0, 8'hFF, 16'h0, 128'h0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_resp_val", 129'(resp_val), 129'(0));
        chk("t6_clear_done", 129'(clear_done), 129'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_clear();
        resp_rdy = 1'b1;
        send(1'b0, 8'h00, 16'h0, 128'h0);
        get_resp(r);
        chk("t6_addr0_zero", r, 129'h0);
        send(1'b0, 8'hFF, 16'h0, 128'h0);
        get_resp(r);
        chk("t6_addrff_zero", r, 129'h0);
        drain();
        credit_test(8'd40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
